// File: rtl/uart_frame_ctrl.sv
// Frame controller behind the UART receiver: header hunt, CMD/LEN/payload/CHK parse,
// tentative payload writes, a single commit pulse on a good checksum, and error pulses.
module uart_frame_ctrl #(
    parameter int CLK_FRE       = 50,
    parameter int BAUD_RATE     = 9600,
    parameter int MAX_LEN       = 128,
    parameter int TIMEOUT_BYTES = 4,
    parameter int AW            = 7
) (
    input  logic          i_clk_sys,
    input  logic          i_rst_n,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_done,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic [7:0]    o_cmd,
    output logic [7:0]    o_frame_len,
    output logic          o_frame_valid,
    output logic          o_err_chk,
    output logic          o_err_len,
    output logic          o_err_timeout,
    output logic          o_busy
);

    localparam longint TIMEOUT_CYC = longint'(TIMEOUT_BYTES) * 64'd10 * longint'(CLK_FRE)
                                     * 64'd1000000 / longint'(BAUD_RATE);
    localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYC - 64'd1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_CMD, S_LEN, S_PAY, S_CHK} state_t;

    state_t        state, state_nxt;
    logic [23:0]   tmo_cnt, tmo_cnt_nxt;
    logic [7:0]    sum, sum_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [7:0]    len, len_nxt;
    logic          wr_en_nxt;
    logic [AW-1:0] wr_addr_nxt;
    logic [7:0]    wr_data_nxt, cmd_nxt, frame_len_nxt;
    logic          valid_nxt, err_chk_nxt, err_len_nxt, err_tmo_nxt;
    logic          expire;

    assign expire = (state != S_HDR0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt     = state;
        sum_nxt       = sum;
        idx_nxt       = idx;
        len_nxt       = len;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = o_wr_addr;
        wr_data_nxt   = o_wr_data;
        cmd_nxt       = o_cmd;
        frame_len_nxt = o_frame_len;
        valid_nxt     = 1'b0;
        err_chk_nxt   = 1'b0;
        err_len_nxt   = 1'b0;
        err_tmo_nxt   = 1'b0;
        tmo_cnt_nxt   = (state == S_HDR0) ? 24'd0 : tmo_cnt + 24'd1;

        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (i_rx_done) begin
            tmo_cnt_nxt = 24'd0;
            case (state)
                S_HDR0: if (i_rx_data == 8'hAA) state_nxt = S_HDR1;
                S_HDR1: begin
                    if (i_rx_data == 8'h55)      state_nxt = S_CMD;
                    else if (i_rx_data != 8'hAA) state_nxt = S_HDR0;
                end
                S_CMD: begin
                    cmd_nxt   = i_rx_data;
                    sum_nxt   = i_rx_data;
                    state_nxt = S_LEN;
                end
                S_LEN: begin
                    if (i_rx_data > MAX_LEN_B) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = S_HDR0;
                    end else begin
                        len_nxt   = i_rx_data;
                        sum_nxt   = sum + i_rx_data;
                        idx_nxt   = 8'd0;
                        state_nxt = (i_rx_data == 8'd0) ? S_CHK : S_PAY;
                    end
                end
                S_PAY: begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = idx[AW-1:0];
                    wr_data_nxt = i_rx_data;
                    idx_nxt     = idx + 8'd1;
                    sum_nxt     = sum + i_rx_data;
                    if (idx == len - 8'd1) state_nxt = S_CHK;
                end
                S_CHK: begin
                    if (i_rx_data == sum) begin
                        valid_nxt     = 1'b1;
                        frame_len_nxt = len;
                    end else begin
                        err_chk_nxt = 1'b1;
                    end
                    state_nxt = S_HDR0;
                end
                default: state_nxt = S_HDR0;
            endcase
        end else if (expire) begin
            err_tmo_nxt = 1'b1;
            tmo_cnt_nxt = 24'd0;
            state_nxt   = S_HDR0;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_HDR0;
            tmo_cnt       <= 24'd0;
            sum           <= 8'd0;
            idx           <= 8'd0;
            len           <= 8'd0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= 8'd0;
            o_cmd         <= 8'd0;
            o_frame_len   <= 8'd0;
            o_frame_valid <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            sum           <= sum_nxt;
            idx           <= idx_nxt;
            len           <= len_nxt;
            o_wr_en       <= wr_en_nxt;
            o_wr_addr     <= wr_addr_nxt;
            o_wr_data     <= wr_data_nxt;
            o_cmd         <= cmd_nxt;
            o_frame_len   <= frame_len_nxt;
            o_frame_valid <= valid_nxt;
            o_err_chk     <= err_chk_nxt;
            o_err_len     <= err_len_nxt;
            o_err_timeout <= err_tmo_nxt;
            o_busy        <= (state_nxt != S_HDR0);
        end
    end

endmodule
